// File: rtl/matrix_stream_packer.sv
// matrix_stream_packer: packs a row-major element stream into an MSB-first matrix vector (PACK_TRANSPOSE_EN stores the transpose)
module matrix_stream_packer #(
   parameter  int ROWS    = 2,
   parameter  int COLS    = 2,
   parameter  int ELEM_W  = 8,
   localparam int MAT_LEN = ROWS * COLS * ELEM_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ELEM_W-1:0]  in_data,
   input  logic               in_valid,
   input  logic               in_sof,
   output logic               in_ready,
   output logic [MAT_LEN-1:0] mat,
   output logic               mat_valid,
   input  logic               mat_ready,
   output logic               frame_err,
   output logic               busy
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   typedef enum logic {S_FILL, S_FULL} state_t;
   state_t r_state, w_state_nxt;
   logic [RW-1:0] r_row, w_r, w_row_nxt;
   logic [CW-1:0] r_col, w_c, w_col_nxt;
   logic [MAT_LEN-1:0] r_mat;
   logic r_err, r_busy;
   logic w_acc, w_resync, w_col_end, w_last;
   logic [31:0] w_slot;
   assign in_ready  = (r_state == S_FILL);
   assign mat_valid = (r_state == S_FULL);
   assign mat       = r_mat;
   assign frame_err = r_err;
   assign busy      = r_busy;
   // Accept/resync decode, effective position of the incoming element, and next position/state
   always_comb begin
      w_acc       = in_valid & (r_state == S_FILL);
      w_resync    = w_acc & in_sof & ((r_row != '0) | (r_col != '0));
      w_r         = w_resync ? '0 : r_row;
      w_c         = w_resync ? '0 : r_col;
      w_col_end   = (w_c == CW'(COLS - 1));
      w_last      = w_acc & w_col_end & (w_r == RW'(ROWS - 1));
      w_col_nxt   = !w_acc ? r_col : w_col_end ? '0 : w_c + CW'(1);
      w_row_nxt   = !w_acc ? r_row : !w_col_end ? w_r : w_last ? '0 : w_r + RW'(1);
`ifdef PACK_TRANSPOSE_EN
      w_slot      = 32'(w_c) * ROWS + 32'(w_r);
`else
      w_slot      = 32'(w_r) * COLS + 32'(w_c);
`endif
      w_state_nxt = r_state;
      if (r_state == S_FILL && w_last) w_state_nxt = S_FULL;
      if (r_state == S_FULL && mat_ready) w_state_nxt = S_FILL;
   end
   // State, position, error pulse and busy flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_FILL;
         r_row   <= '0;
         r_col   <= '0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         r_col   <= w_col_nxt;
         r_err   <= w_resync;
         r_busy  <= w_acc ? !w_last : r_busy;
      end
   end
   // Element write into its byte lane; untouched lanes keep stale data between frames
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mat <= '0;
      end else begin
         for (int n = 0; n < ROWS * COLS; n++)
            if (w_acc && w_slot == n) r_mat[MAT_LEN-1-n*ELEM_W -: ELEM_W] <= in_data;
      end
   end
endmodule
